// File: rtl/shape_processor_ctrl_writer_if.sv
// Request/response handshake plus the shape-processor register bus
// for shape_processor_ctrl_writer.
interface shape_processor_ctrl_writer_if #(
  parameter int SHAPE_W = 4,
  parameter int OP_W    = 4
);
  logic               req_valid;
  logic               req_ready;
  logic [SHAPE_W-1:0] req_shape;
  logic [OP_W-1:0]    req_op;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_status;
  logic [31:0]        rsp_sfr;
  logic               write;
  logic [31:0]        write_data;
  logic               read;
  logic [31:0]        read_data;
  logic               error;

  modport master (
    output req_valid, req_shape, req_op, rsp_ready, read_data, error,
    input  req_ready, rsp_valid, rsp_status, rsp_sfr, write, write_data, read
  );

  modport slave (
    input  req_valid, req_shape, req_op, rsp_ready, read_data, error,
    output req_ready, rsp_valid, rsp_status, rsp_sfr, write, write_data, read
  );
endinterface

// File: rtl/shape_processor_ctrl_writer.sv
// Writes SHAPE/OPERATION into the shape processor control word, reads it back
// and classifies the outcome against a shadow copy of the register.
module shape_processor_ctrl_writer #(
  parameter int SHAPE_LSB = 0,
  parameter int SHAPE_W   = 4,
  parameter int OP_LSB    = 4,
  parameter int OP_W      = 4
) (
  input logic                          clk,
  input logic                          rst,
  shape_processor_ctrl_writer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, PRE_RD, PRE_WAIT, WR, RD, RD_WAIT, RESP
  } state_t;

  localparam logic [SHAPE_W-1:0] KEEP_SHAPE = '1;
  localparam logic [OP_W-1:0]    KEEP_OP    = '1;

  state_t             state_r, state_s;
  logic [SHAPE_W-1:0] shape_r, lat_shape_s;
  logic [OP_W-1:0]    op_r, lat_op_s;
  logic [31:0]        shadow_r;
  logic               shadow_valid_r;
  logic               err_seen_r;
  logic               req_ready_r, rsp_valid_r, write_r, read_r;
  logic [1:0]         rsp_status_r;
  logic [31:0]        rsp_sfr_r, write_data_r;

  function automatic logic [31:0] field_word(input logic [SHAPE_W-1:0] shape,
                                             input logic [OP_W-1:0] op);
    logic [31:0] w;
    w = 32'd0;
    w[SHAPE_LSB +: SHAPE_W] = shape;
    w[OP_LSB +: OP_W]       = op;
    return w;
  endfunction

  function automatic logic [31:0] expected_word(input logic [31:0] shadow,
                                                input logic [SHAPE_W-1:0] shape,
                                                input logic [OP_W-1:0] op);
    logic [31:0] w;
    w = shadow;
    if (shape != KEEP_SHAPE) w[SHAPE_LSB +: SHAPE_W] = shape;
    if (op != KEEP_OP)       w[OP_LSB +: OP_W]       = op;
    return w;
  endfunction

  function automatic logic fields_eq(input logic [31:0] a, input logic [31:0] b);
    return (a[SHAPE_LSB +: SHAPE_W] == b[SHAPE_LSB +: SHAPE_W]) &&
           (a[OP_LSB +: OP_W] == b[OP_LSB +: OP_W]);
  endfunction

  // ERROR dominates; a readback still matching the old shadow means the write was refused
  function automatic logic [1:0] status_of(input logic err, input logic [31:0] rb,
                                           input logic [31:0] exp_w,
                                           input logic [31:0] shadow);
    if (err)                        return 2'b11;
    else if (fields_eq(rb, exp_w))  return 2'b00;
    else if (fields_eq(rb, shadow)) return 2'b01;
    else                            return 2'b10;
  endfunction

  // next state, and the request fields as they will stand once latched
  always_comb begin
    state_s     = state_r;
    lat_shape_s = shape_r;
    lat_op_s    = op_r;
    if (state_r == IDLE) begin
      lat_shape_s = bus.req_shape;
      lat_op_s    = bus.req_op;
    end else begin
      lat_shape_s = shape_r;
      lat_op_s    = op_r;
    end
    case (state_r)
      IDLE: begin
        if (bus.req_valid) state_s = shadow_valid_r ? WR : PRE_RD;
        else               state_s = IDLE;
      end
      PRE_RD:   state_s = PRE_WAIT;
      PRE_WAIT: state_s = WR;
      WR:       state_s = RD;
      RD:       state_s = RD_WAIT;
      RD_WAIT:  state_s = RESP;
      RESP: begin
        if (bus.rsp_ready) state_s = IDLE;
        else               state_s = RESP;
      end
      default:  state_s = IDLE;
    endcase
  end

  // state, registered strobes and the transaction datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      shape_r        <= '0;
      op_r           <= '0;
      shadow_r       <= 32'd0;
      shadow_valid_r <= 1'b0;
      err_seen_r     <= 1'b0;
      req_ready_r    <= 1'b1;
      rsp_valid_r    <= 1'b0;
      rsp_status_r   <= 2'b00;
      rsp_sfr_r      <= 32'd0;
      write_r        <= 1'b0;
      write_data_r   <= 32'd0;
      read_r         <= 1'b0;
    end else begin
      state_r      <= state_s;
      req_ready_r  <= (state_s == IDLE);
      rsp_valid_r  <= (state_s == RESP);
      write_r      <= (state_s == WR);
      write_data_r <= (state_s == WR) ? field_word(lat_shape_s, lat_op_s) : 32'd0;
      read_r       <= (state_s == PRE_RD) || (state_s == RD);
      if (state_r == IDLE && bus.req_valid) begin
        shape_r <= bus.req_shape;
        op_r    <= bus.req_op;
      end
      if (state_r == PRE_WAIT) begin
        shadow_r       <= bus.read_data;
        shadow_valid_r <= 1'b1;
      end
      if (state_r == RD) err_seen_r <= bus.error;
      if (state_r == RD_WAIT) begin
        rsp_sfr_r    <= bus.read_data;
        rsp_status_r <= status_of(err_seen_r, bus.read_data,
                                  expected_word(shadow_r, shape_r, op_r), shadow_r);
        shadow_r     <= bus.read_data;
      end
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_status = rsp_status_r;
  assign bus.rsp_sfr    = rsp_sfr_r;
  assign bus.write      = write_r;
  assign bus.write_data = write_data_r;
  assign bus.read       = read_r;

endmodule

// File: doc/shape_processor_ctrl_writer.md
SHAPE_PROCESSOR_CTRL_WRITER -- requirements
Module: shape_processor_ctrl_writer

Interface
REQ-001 SHALL have parameter SHAPE_LSB, default 0: bit position of the SHAPE field in the control word.
REQ-002 SHALL have parameter SHAPE_W, default 4: SHAPE field width; all-ones encodes KEEP_SHAPE.
REQ-003 SHALL have parameter OP_LSB, default 4: bit position of the OPERATION field.
REQ-004 SHALL have parameter OP_W, default 4: OPERATION field width; all-ones encodes KEEP_OPERATION.
REQ-005 SHALL have one clock and an asynchronous active-high reset, ports as follows: clk  in  1  clock, all logic on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  request accepted when high together with req_valid.
REQ-009 req_shape  in  SHAPE_W  requested shape or KEEP_SHAPE.
REQ-010 req_op  in  OP_W  requested operation or KEEP_OPERATION.
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  response consumed.
REQ-013 rsp_status  out  2  00 OK, 01 REJECTED, 10 MISMATCH, 11 ERROR.
REQ-014 rsp_sfr  out  32  control word read back after the write.
REQ-015 write  out  1  one-cycle write strobe to the shape processor.
REQ-016 write_data  out  32  control word, valid while write=1.
REQ-017 read  out  1  one-cycle read strobe.
REQ-018 read_data  in  32  read result, valid the cycle after read=1.
REQ-019 error  in  1  processor error flag, valid the cycle after write=1.

Function
REQ-020 SHALL implement FSM states IDLE, PRE_RD, PRE_WAIT, WR, RD, RD_WAIT, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; req_valid outside IDLE SHALL be ignored.
REQ-022 On accept, req_shape/req_op SHALL be latched; next state PRE_RD if shadow_valid=0, else WR.
REQ-023 PRE_RD SHALL drive read=1 for one cycle; PRE_WAIT SHALL load the shadow register from read_data, set shadow_valid=1, and go to WR.
REQ-024 WR SHALL drive write=1 for one cycle with write_data = latched shape at SHAPE field, latched op at OP field, all other bits 0.
REQ-025 write_data SHALL be 0 whenever write=0.
REQ-026 RD SHALL drive read=1 and sample error into err_seen.
REQ-027 RD_WAIT SHALL capture read_data into rsp_sfr, compute rsp_status, load shadow with read_data, and go to RESP.
REQ-028 Expected word SHALL be the shadow with SHAPE replaced by latched shape unless KEEP_SHAPE, and OPERATION replaced by latched op unless KEEP_OPERATION.
REQ-029 rsp_status priority: ERROR if err_seen; else OK if readback SHAPE and OPERATION fields equal expected; else REJECTED if equal to prior shadow fields; else MISMATCH.
REQ-030 A KEEP_SHAPE/KEEP_OPERATION pair SHALL still issue the write; its expected word equals the shadow, so the result is OK or MISMATCH, never REJECTED.
REQ-031 RESP SHALL hold rsp_valid, rsp_status, rsp_sfr stable until rsp_ready=1, then go to IDLE on that edge.
REQ-032 Latency with shadow_valid=1: write in cycle 1 after accept, read in cycle 2, rsp_valid in cycle 4; with shadow_valid=0: add 2 cycles.
REQ-033 write and read SHALL never be high in the same cycle.

Reset
REQ-034 While rst=1: state IDLE, req_ready=1, rsp_valid=0, rsp_status=00, rsp_sfr=0, write=0, write_data=0, read=0, shadow=0, shadow_valid=0, err_seen=0.
REQ-035 Reset asserted mid-transaction SHALL abort it with no response; the first request after reset SHALL perform the pre-read.

Verification
REQ-036 After reset, req shape=2 op=1, processor returns 0x00 then 0x12, error=0 -> read, write 0x12, read, rsp_status=00, rsp_sfr=0x12, rsp_valid 6 cycles after accept.
REQ-037 Shadow 0x12, req shape=0xF op=3, readback 0x32 -> write_data=0x3F, status 00, latency 4 cycles.
REQ-038 Shadow 0x12, req shape=5 op=7, readback 0x12 -> status 01 REJECTED.
REQ-039 Shadow 0x12, req shape=5 op=2, error=1 the cycle after write, readback 0x12 -> status 11 ERROR.
REQ-040 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_status/rsp_sfr stable, req_ready=0, new req_valid ignored.
REQ-041 rst pulsed during RD -> read=0, rsp_valid=0 next cycle; next request begins with a pre-read.
